// File: rtl/counter_pkg.sv
// Shared types for the up/down digit counter: per-digit nibble type, radix
// selection, and the largest legal digit for each radix.
package counter_pkg;

   typedef logic [3:0] digit_t;

   typedef enum logic {RADIX_HEX, RADIX_DEC} radix_t;

   function automatic digit_t digit_max(radix_t radix);
      return (radix == RADIX_DEC) ? 4'h9 : 4'hF;
   endfunction

endpackage

// File: rtl/updown_digit_counter_if.sv
// Event and display bundle between the button debouncers, the digit counter
// and the seven-segment driver.
interface updown_digit_counter_if #(
   parameter int NUM_SEGMENTS = 4
);
   logic                         inc;
   logic                         dec;
   logic                         clr;
   logic [NUM_SEGMENTS-1:0][3:0] encoded;
   logic [NUM_SEGMENTS-1:0]      digit_point;
   logic                         overflow;
   logic                         underflow;

   modport master (
      output inc, dec, clr,
      input  encoded, digit_point, overflow, underflow
   );

   modport slave (
      input  inc, dec, clr,
      output encoded, digit_point, overflow, underflow
   );
endinterface

// File: rtl/updown_digit_cell.sv
// One digit of the ripple counter: applies an increment or decrement request
// and reports wrap as carry_out/borrow_out to the next more-significant digit.
module updown_digit_cell
   import counter_pkg::*;
(
   input  digit_t digit,
   input  logic   up,
   input  logic   down,
   input  radix_t radix,
   output digit_t next_digit,
   output logic   carry_out,
   output logic   borrow_out
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      next_digit = digit;
      carry_out  = 1'b0;
      borrow_out = 1'b0;
      if (up && !down) begin
         // >= also pulls an out-of-range digit back into the legal range.
         if (digit >= digit_max(radix)) begin
            next_digit = '0;
            carry_out  = 1'b1;
         end else begin
            next_digit = digit + 4'd1;
         end
      end else if (down && !up) begin
         if (digit == '0) begin
            next_digit = digit_max(radix);
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/updown_digit_counter.sv
// Multi-digit HEX/BCD up/down event counter with wrap flags and a digit-0 point
// that stays lit for DP_HOLD_CYC cycles after each event. Optional: COUNTER_SATURATE_EN.
module updown_digit_counter
   import counter_pkg::*;
#(
   parameter     MODE         = "HEX",
   parameter int NUM_SEGMENTS = 4,
   parameter int DP_HOLD_CYC  = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   updown_digit_counter_if.slave  bus
);

   localparam radix_t RADIX = (MODE == "DEC") ? RADIX_DEC : RADIX_HEX;
   localparam int     TW    = (DP_HOLD_CYC > 0) ? $clog2(DP_HOLD_CYC + 1) : 1;
   localparam logic [TW-1:0] HOLD = TW'(DP_HOLD_CYC);

`ifdef COUNTER_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   logic                         inc_evt;
   logic                         dec_evt;
   logic                         accept;
   logic                         wrap;
   logic [NUM_SEGMENTS:0]        carry;
   logic [NUM_SEGMENTS:0]        borrow;
   logic [NUM_SEGMENTS-1:0][3:0] next_enc;
   logic [TW-1:0]                timer;
   logic [TW-1:0]                timer_next;
   logic                         dp0;

   // clr outranks counting; simultaneous inc and dec cancel out entirely.
   assign inc_evt  = bus.inc && !bus.dec && !bus.clr;
   assign dec_evt  = bus.dec && !bus.inc && !bus.clr;
   assign accept   = bus.clr || (bus.inc ^ bus.dec);
   assign carry[0]  = inc_evt;
   assign borrow[0] = dec_evt;
   assign wrap      = carry[NUM_SEGMENTS] || borrow[NUM_SEGMENTS];

   for (genvar i = 0; i < NUM_SEGMENTS; i++) begin : g_digit
      updown_digit_cell u_cell (
         .digit      (bus.encoded[i]),
         .up         (carry[i]),
         .down       (borrow[i]),
         .radix      (RADIX),
         .next_digit (next_enc[i]),
         .carry_out  (carry[i+1]),
         .borrow_out (borrow[i+1])
      );
   end

   always_comb begin
      timer_next = timer;
      if (accept) begin
         timer_next = HOLD;
      end else if (timer != '0) begin
         timer_next = timer - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         bus.encoded   <= '0;
         bus.overflow  <= 1'b0;
         bus.underflow <= 1'b0;
         timer         <= '0;
         dp0           <= 1'b0;
      end else begin
         bus.overflow  <= carry[NUM_SEGMENTS];
         bus.underflow <= borrow[NUM_SEGMENTS];
         if (bus.clr) begin
            bus.encoded <= '0;
         end else if (!(SATURATE && wrap)) begin
            bus.encoded <= next_enc;
         end
         timer <= timer_next;
         dp0   <= (timer_next != '0);
      end
   end

   always_comb begin
      bus.digit_point    = '0;
      bus.digit_point[0] = dp0;
   end

endmodule

// File: tb/tb_updown_digit_counter.sv
// Self-checking bench: a HEX and a DEC two-digit counter share one stimulus
// stream and are compared every cycle against an integer-valued reference model.
module tb_updown_digit_counter;

   localparam int N    = 2;
   localparam int HOLD = 4;

`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;

   updown_digit_counter_if #(.NUM_SEGMENTS(N)) bus_h ();
   updown_digit_counter_if #(.NUM_SEGMENTS(N)) bus_d ();

   updown_digit_counter #(.MODE("HEX"), .NUM_SEGMENTS(N), .DP_HOLD_CYC(HOLD)) dut_hex (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_h)
   );

   updown_digit_counter #(.MODE("DEC"), .NUM_SEGMENTS(N), .DP_HOLD_CYC(HOLD)) dut_dec (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_d)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the counter as a plain integer in [0, R**N - 1].
   int radix_of [2] = '{16, 10};
   int val      [2];
   int tmr      [2];
   bit ovf      [2];
   bit unf      [2];
   bit model_on = 1'b0;

   function automatic logic [31:0] to_digits(input int v, input int r);
      logic [31:0] res = '0;
      int          p   = 1;
      for (int i = 0; i < N; i++) begin
         res[i*4 +: 4] = 4'((v / p) % r);
         p = p * r;
      end
      return res;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int maxv;
         maxv = radix_of[k] ** N - 1;
         if (reset) begin
            val[k] = 0; tmr[k] = 0; ovf[k] = 1'b0; unf[k] = 1'b0;
         end else begin
            ovf[k] = 1'b0;
            unf[k] = 1'b0;
            if (bus_h.clr) begin
               val[k] = 0;
            end else if (bus_h.inc && !bus_h.dec) begin
               if (val[k] == maxv) begin
                  ovf[k] = 1'b1;
                  val[k] = SAT ? maxv : 0;
               end else begin
                  val[k] = val[k] + 1;
               end
            end else if (bus_h.dec && !bus_h.inc) begin
               if (val[k] == 0) begin
                  unf[k] = 1'b1;
                  val[k] = SAT ? 0 : maxv;
               end else begin
                  val[k] = val[k] - 1;
               end
            end
            if (bus_h.clr || (bus_h.inc ^ bus_h.dec)) tmr[k] = HOLD;
            else if (tmr[k] > 0) tmr[k] = tmr[k] - 1;
         end
      end
      if (reset) model_on = 1'b1;
   end

   // Every-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      if (model_on) begin
         check("enc_hex", 32'(bus_h.encoded), to_digits(val[0], 16));
         check("dp_hex",  32'(bus_h.digit_point), (tmr[0] != 0) ? 32'd1 : 32'd0);
         check("ovf_hex", 32'(bus_h.overflow),  32'(ovf[0]));
         check("unf_hex", 32'(bus_h.underflow), 32'(unf[0]));
         check("enc_dec", 32'(bus_d.encoded), to_digits(val[1], 10));
         check("dp_dec",  32'(bus_d.digit_point), (tmr[1] != 0) ? 32'd1 : 32'd0);
         check("ovf_dec", 32'(bus_d.overflow),  32'(ovf[1]));
         check("unf_dec", 32'(bus_d.underflow), 32'(unf[1]));
      end
   end

   // One clock of stimulus; returns just after the following falling edge.
   task automatic step(input logic i, input logic d, input logic c, input logic r);
      bus_h.inc = i; bus_h.dec = d; bus_h.clr = c;
      bus_d.inc = i; bus_d.dec = d; bus_d.clr = c;
      reset = r;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic repeat_step(input int n, input logic i, input logic d);
      for (int j = 0; j < n; j++) step(i, d, 1'b0, 1'b0);
   endtask

   initial begin
      bus_h.inc = 1'b0; bus_h.dec = 1'b0; bus_h.clr = 1'b0;
      bus_d.inc = 1'b0; bus_d.dec = 1'b0; bus_d.clr = 1'b0;
      @(negedge clk);

      // Reset state.
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("lit_reset_enc", 32'(bus_d.encoded), 32'h00);
      check("lit_reset_dp",  32'(bus_d.digit_point), 32'h0);
      check("lit_reset_ovf", 32'(bus_d.overflow), 32'h0);

      // Nine then ten increments in DEC; HEX shows 0x0A after ten.
      repeat_step(9, 1, 0);
      check("lit_dec_9",  32'(bus_d.encoded), 32'h09);
      check("lit_dec_dp", 32'(bus_d.digit_point), 32'h1);
      step(1, 0, 0, 0);
      check("lit_dec_10", 32'(bus_d.encoded), 32'h10);
      check("lit_hex_10", 32'(bus_h.encoded), 32'h0A);

      // DEC overflow from 99.
      step(0, 0, 0, 1);
      repeat_step(99, 1, 0);
      check("lit_dec_99", 32'(bus_d.encoded), 32'h99);
      check("lit_hex_99", 32'(bus_h.encoded), 32'h63);
      step(1, 0, 0, 0);
      check("lit_dec_wrap",     32'(bus_d.encoded), SAT ? 32'h99 : 32'h00);
      check("lit_dec_ovf",      32'(bus_d.overflow), 32'h1);
      check("lit_hex_no_ovf",   32'(bus_h.overflow), 32'h0);
      step(0, 0, 0, 0);
      check("lit_dec_ovf_drop", 32'(bus_d.overflow), 32'h0);

      // HEX underflow at 00, then increment back.
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      check("lit_hex_under",   32'(bus_h.encoded), SAT ? 32'h00 : 32'hFF);
      check("lit_hex_unf",     32'(bus_h.underflow), 32'h1);
      check("lit_dec_under",   32'(bus_d.encoded), SAT ? 32'h00 : 32'h99);
      step(0, 0, 0, 0);
      check("lit_hex_unf_drop", 32'(bus_h.underflow), 32'h0);
      step(1, 0, 0, 0);
      check("lit_hex_over",    32'(bus_h.encoded), SAT ? 32'h01 : 32'h00);
      check("lit_hex_ovf",     32'(bus_h.overflow), SAT ? 32'h0 : 32'h1);

      // inc+dec together at 0x05, then clr+inc at 0x42.
      step(0, 0, 0, 1);
      repeat_step(5, 1, 0);
      repeat_step(6, 0, 0);
      step(1, 1, 0, 0);
      check("lit_both_enc", 32'(bus_h.encoded), 32'h05);
      check("lit_both_dp",  32'(bus_h.digit_point), 32'h0);
      check("lit_both_ovf", 32'(bus_h.overflow), 32'h0);
      repeat_step(61, 1, 0);
      check("lit_hex_42", 32'(bus_h.encoded), 32'h42);
      step(1, 0, 1, 0);
      check("lit_clr_enc", 32'(bus_h.encoded), 32'h00);
      check("lit_clr_dp",  32'(bus_h.digit_point), 32'h1);

      // DP hold: single event, then an event that extends the hold.
      repeat_step(6, 0, 0);
      check("lit_dp_idle", 32'(bus_h.digit_point), 32'h0);
      step(1, 0, 0, 0);
      for (int j = 0; j < 3; j++) begin
         check("lit_dp_hold", 32'(bus_h.digit_point), 32'h1);
         step(0, 0, 0, 0);
      end
      check("lit_dp_hold4", 32'(bus_h.digit_point), 32'h1);
      step(0, 0, 0, 0);
      check("lit_dp_off", 32'(bus_h.digit_point), 32'h0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int j = 0; j < 3; j++) begin
         step(0, 0, 0, 0);
         check("lit_dp_ext", 32'(bus_h.digit_point), 32'h1);
      end
      step(0, 0, 0, 0);
      check("lit_dp_ext_off", 32'(bus_h.digit_point), 32'h0);

      // Reset mid-count at 0x37 with a pending inc.
      step(0, 0, 0, 1);
      repeat_step(55, 1, 0);
      check("lit_hex_37", 32'(bus_h.encoded), 32'h37);
      step(1, 0, 0, 1);
      check("lit_rst_enc", 32'(bus_h.encoded), 32'h00);
      check("lit_rst_dp",  32'(bus_h.digit_point), 32'h0);
      check("lit_rst_ovf", 32'(bus_h.overflow), 32'h0);
      step(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
